// File: rtl/idu_pkg.sv
// Shared decode constants: opcodes, ALU / write-back encodings, stage states
// and the control bundle carried from the decoder to the EXU.
package idu_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_IMM = 2'd1,
      WB_PC4 = 2'd2,
      WB_MEM = 2'd3
   } wb_sel_e;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_HALT  = 2'd2
   } state_e;

   typedef struct packed {
      logic      reg_write;
      logic      alu_src;
      logic      alu_r1;
      alu_ctrl_e alu_ctrl;
      wb_sel_e   wb_sel;
      logic      is_jal;
      logic      is_jalr;
      logic      is_branch;
      logic      mem_read;
      logic      mem_write;
   } ctrl_t;

   // alt is instruction bit 30 where it selects SUB/SRA, otherwise 0
   function automatic alu_ctrl_e alu_op(input logic [2:0] funct3, input logic alt);
      case (funct3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/idu_decode.sv
// Combinational RV32I/RV32E decoder: instruction word to control bundle,
// sign-extended immediate, EBREAK and illegal flags.
module idu_decode
   import idu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NR_REG = 32
) (
   input  logic [31:0]     inst_i,
   output ctrl_t           ctrl_o,
   output logic [XLEN-1:0] imm_o,
   output logic            ebreak_o,
   output logic            illegal_o
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm32;
   logic        use_rs1, use_rs2, use_rd;

   assign opcode = inst_i[6:0];
   assign funct3 = inst_i[14:12];
   assign funct7 = inst_i[31:25];
   assign imm_o  = XLEN'($signed(imm32));

   always_comb begin
      ctrl_o    = '0;
      imm32     = '0;
      ebreak_o  = 1'b0;
      illegal_o = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      use_rd    = 1'b0;

      case (opcode)
         OPC_LUI: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wb_sel    = WB_IMM;
            imm32            = {inst_i[31:12], 12'b0};
            use_rd           = 1'b1;
         end
         OPC_AUIPC: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_r1    = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            imm32            = {inst_i[31:12], 12'b0};
            use_rd           = 1'b1;
         end
         OPC_OP_IMM: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_ctrl  = alu_op(funct3, (funct3 == 3'd5) && inst_i[30]);
            imm32            = {{20{inst_i[31]}}, inst_i[31:20]};
            use_rs1          = 1'b1;
            use_rd           = 1'b1;
            if ((funct3 == 3'd1 && funct7 != 7'h00) ||
                (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20))
               illegal_o = 1'b1;
         end
         OPC_OP: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_ctrl  = alu_op(funct3, inst_i[30]);
            use_rs1          = 1'b1;
            use_rs2          = 1'b1;
            use_rd           = 1'b1;
            if (!(funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'd0 || funct3 == 3'd5))))
               illegal_o = 1'b1;
         end
         OPC_JAL: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wb_sel    = WB_PC4;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.alu_r1    = 1'b1;
            ctrl_o.is_jal    = 1'b1;
            imm32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            use_rd           = 1'b1;
         end
         OPC_JALR: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.wb_sel    = WB_PC4;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.is_jalr   = 1'b1;
            imm32            = {{20{inst_i[31]}}, inst_i[31:20]};
            use_rs1          = 1'b1;
            use_rd           = 1'b1;
            illegal_o        = (funct3 != 3'd0);
         end
         OPC_BRANCH: begin
            ctrl_o.alu_ctrl  = ALU_SUB;
            ctrl_o.is_branch = 1'b1;
            imm32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            use_rs1          = 1'b1;
            use_rs2          = 1'b1;
            illegal_o        = (funct3 == 3'd2) || (funct3 == 3'd3);
         end
         OPC_LOAD: begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_read  = 1'b1;
            ctrl_o.wb_sel    = WB_MEM;
            imm32            = {{20{inst_i[31]}}, inst_i[31:20]};
            use_rs1          = 1'b1;
            use_rd           = 1'b1;
            illegal_o        = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
         end
         OPC_STORE: begin
            ctrl_o.alu_src   = 1'b1;
            ctrl_o.mem_write = 1'b1;
            imm32            = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            use_rs1          = 1'b1;
            use_rs2          = 1'b1;
            illegal_o        = (funct3 >= 3'd3);
         end
         OPC_SYSTEM: begin
            ebreak_o  = (inst_i == INST_EBREAK);
            illegal_o = (inst_i != INST_EBREAK);
         end
         default: illegal_o = 1'b1;
      endcase

      // RV32E only has x0..x15, so bit 4 of any field the format reads is out of range
      if (NR_REG == 16 && ((use_rs1 && inst_i[19]) || (use_rs2 && inst_i[24]) ||
                           (use_rd && inst_i[11])))
         illegal_o = 1'b1;

      if (illegal_o || ebreak_o) begin
         ctrl_o.reg_write = 1'b0;
         ctrl_o.mem_read  = 1'b0;
         ctrl_o.mem_write = 1'b0;
         ctrl_o.is_jal    = 1'b0;
         ctrl_o.is_jalr   = 1'b0;
         ctrl_o.is_branch = 1'b0;
      end
   end

endmodule

// File: rtl/idu_pipe.sv
// Registered decode stage: one-entry valid/ready pipeline around idu_decode,
// sticky halt after an EBREAK/illegal bundle drains, accepted-instruction counter.
module idu_pipe
   import idu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NR_REG = 32,
   parameter int CNT_W  = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [XLEN-1:0]  out_imm,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic [4:0]       out_rd,
   output logic [2:0]       out_funct3,
   output logic             out_reg_write,
   output logic             out_alu_src,
   output logic             out_alu_r1,
   output logic [3:0]       out_alu_ctrl,
   output logic [1:0]       out_wb_sel,
   output logic             out_is_jal,
   output logic             out_is_jalr,
   output logic             out_is_branch,
   output logic             out_mem_read,
   output logic             out_mem_write,
   output logic             out_ebreak,
   output logic             out_illegal,
   output logic             halt,
   output logic [CNT_W-1:0] dec_cnt
);

   state_e            state_q, state_d;
   ctrl_t             ctrl_q, dec_ctrl;
   logic [XLEN-1:0]   pc_q, imm_q, dec_imm;
   logic [4:0]        rs1_q, rs2_q, rd_q;
   logic [2:0]        funct3_q;
   logic              ebreak_q, illegal_q, dec_ebreak, dec_illegal;
   logic [CNT_W-1:0]  cnt_q;
   logic              accept;
   logic              halting;

   idu_decode #(.XLEN(XLEN), .NR_REG(NR_REG)) u_decode (
      .inst_i    (in_inst),
      .ctrl_o    (dec_ctrl),
      .imm_o     (dec_imm),
      .ebreak_o  (dec_ebreak),
      .illegal_o (dec_illegal)
   );

   assign halting = ebreak_q | illegal_q;
   assign accept  = in_valid & in_ready;

   // A held halting bundle blocks intake so nothing ever follows it
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ST_FULL;
         end
         ST_FULL: begin
            if (out_ready) begin
               if (halting) begin
                  state_d = ST_HALT;
               end else begin
                  in_ready = 1'b1;
                  state_d  = in_valid ? ST_FULL : ST_EMPTY;
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_EMPTY;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= '0;
         pc_q      <= '0;
         imm_q     <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         rd_q      <= '0;
         funct3_q  <= '0;
         ebreak_q  <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else if (accept) begin
         ctrl_q    <= dec_ctrl;
         pc_q      <= in_pc;
         imm_q     <= dec_imm;
         rs1_q     <= in_inst[19:15];
         rs2_q     <= in_inst[24:20];
         rd_q      <= in_inst[11:7];
         funct3_q  <= in_inst[14:12];
         ebreak_q  <= dec_ebreak;
         illegal_q <= dec_illegal;
         cnt_q     <= cnt_q + 1'b1;
      end
   end

   assign out_valid     = (state_q == ST_FULL);
   assign halt          = (state_q == ST_HALT);
   assign dec_cnt       = cnt_q;
   assign out_pc        = pc_q;
   assign out_imm       = imm_q;
   assign out_rs1       = rs1_q;
   assign out_rs2       = rs2_q;
   assign out_rd        = rd_q;
   assign out_funct3    = funct3_q;
   assign out_reg_write = ctrl_q.reg_write;
   assign out_alu_src   = ctrl_q.alu_src;
   assign out_alu_r1    = ctrl_q.alu_r1;
   assign out_alu_ctrl  = ctrl_q.alu_ctrl;
   assign out_wb_sel    = ctrl_q.wb_sel;
   assign out_is_jal    = ctrl_q.is_jal;
   assign out_is_jalr   = ctrl_q.is_jalr;
   assign out_is_branch = ctrl_q.is_branch;
   assign out_mem_read  = ctrl_q.mem_read;
   assign out_mem_write = ctrl_q.mem_write;
   assign out_ebreak    = ebreak_q;
   assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_idu_pipe.sv
// Bench for idu_pipe (RV32E build): decode vector table plus stall, halt and
// reset sequences, checked by a one-entry scoreboard sampled on the falling edge.
module tb_idu_pipe;

   localparam int XLEN   = 32;
   localparam int NR_REG = 16;
   localparam int CNT_W  = 32;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] imm;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic        rw, asrc, ar1;
      logic [3:0]  actl;
      logic [1:0]  wb;
      logic        jal, jalr, br, mr, mw, eb, ill;
   } bundle_t;

   typedef struct {
      logic [31:0] inst;
      bundle_t     exp;
   } vec_t;

   logic             clk;
   logic             rst_n;
   logic             in_valid, in_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc;
   logic             out_valid, out_ready;
   logic [XLEN-1:0]  out_pc, out_imm;
   logic [4:0]       out_rs1, out_rs2, out_rd;
   logic [2:0]       out_funct3;
   logic             out_reg_write, out_alu_src, out_alu_r1;
   logic [3:0]       out_alu_ctrl;
   logic [1:0]       out_wb_sel;
   logic             out_is_jal, out_is_jalr, out_is_branch, out_mem_read, out_mem_write;
   logic             out_ebreak, out_illegal, halt;
   logic [CNT_W-1:0] dec_cnt;

   idu_pipe #(.XLEN(XLEN), .NR_REG(NR_REG), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm),
      .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_funct3(out_funct3),
      .out_reg_write(out_reg_write), .out_alu_src(out_alu_src), .out_alu_r1(out_alu_r1),
      .out_alu_ctrl(out_alu_ctrl), .out_wb_sel(out_wb_sel),
      .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr), .out_is_branch(out_is_branch),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
      .out_ebreak(out_ebreak), .out_illegal(out_illegal),
      .halt(halt), .dec_cnt(dec_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int      n_cmp = 0;
   int      n_bad = 0;
   int      n_txn = 0;
   bundle_t sb[$];
   bundle_t cur_exp;
   logic    halt_m = 1'b0;
   int      cnt_m  = 0;
   bit      acc_flag = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // flags order: rw, asrc, ar1, jal, jalr, br, mr, mw, eb, ill
   function automatic bundle_t mk(input logic [31:0] inst, input logic [31:0] pc,
                                  input logic [31:0] imm, input logic [3:0] actl,
                                  input logic [1:0] wb, input logic [9:0] fl);
      bundle_t b;
      b.pc   = pc;
      b.imm  = imm;
      b.rs1  = inst[19:15];
      b.rs2  = inst[24:20];
      b.rd   = inst[11:7];
      b.f3   = inst[14:12];
      b.actl = actl;
      b.wb   = wb;
      {b.rw, b.asrc, b.ar1, b.jal, b.jalr, b.br, b.mr, b.mw, b.eb, b.ill} = fl;
      return b;
   endfunction

   // Scoreboard: predicts handshakes from its own state, compares the held bundle every cycle
   always @(negedge clk) begin
      bundle_t act;
      logic    full_m, rdy_m, hold_halt, xfer, acc;
      act.pc   = out_pc;       act.imm  = out_imm;
      act.rs1  = out_rs1;      act.rs2  = out_rs2;    act.rd = out_rd;
      act.f3   = out_funct3;   act.rw   = out_reg_write;
      act.asrc = out_alu_src;  act.ar1  = out_alu_r1;
      act.actl = out_alu_ctrl; act.wb   = out_wb_sel;
      act.jal  = out_is_jal;   act.jalr = out_is_jalr; act.br = out_is_branch;
      act.mr   = out_mem_read; act.mw   = out_mem_write;
      act.eb   = out_ebreak;   act.ill  = out_illegal;
      if (!rst_n) begin
         sb.delete();
         cnt_m    = 0;
         halt_m   = 1'b0;
         acc_flag = 0;
         chk("rst_out_valid", 128'(out_valid), 128'(0));
         chk("rst_halt", 128'(halt), 128'(0));
         chk("rst_dec_cnt", 128'(dec_cnt), 128'(0));
         chk("rst_bundle", 128'(act), 128'(0));
      end else begin
         full_m    = (sb.size() != 0);
         hold_halt = full_m ? (sb[0].eb | sb[0].ill) : 1'b0;
         rdy_m     = !halt_m && (!full_m || (out_ready && !hold_halt));
         chk("out_valid", 128'(out_valid), 128'(full_m));
         chk("in_ready", 128'(in_ready), 128'(rdy_m));
         chk("halt", 128'(halt), 128'(halt_m));
         chk("dec_cnt", 128'(dec_cnt), 128'(cnt_m));
         if (full_m) chk("bundle", 128'(act), 128'(sb[0]));
         xfer = full_m && out_ready;
         acc  = in_valid && rdy_m;
         if (xfer) begin
            $display("txn %0d: pc=%h imm=%h rd=%0d alu=%0d wb=%0d ebreak=%0d illegal=%0d",
                     n_txn, act.pc, act.imm, act.rd, act.actl, act.wb, act.eb, act.ill);
            n_txn++;
            if (hold_halt) halt_m = 1'b1;
            void'(sb.pop_front());
         end
         if (acc) begin
            sb.push_back(cur_exp);
            cnt_m++;
         end
         acc_flag = acc;
      end
   end

   task automatic drive(input logic [31:0] inst, input bundle_t e);
      in_valid = 1'b1;
      in_inst  = inst;
      in_pc    = e.pc;
      cur_exp  = e;
   endtask

   task automatic wait_acc(input string name);
      bit got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
         @(posedge clk); #1;
         got = acc_flag;
      end
      n_cmp++;
      if (!got) begin
         n_bad++;
         $display("FAIL %s: accepted=0 required=1", name);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
      rst_n = 1'b1;
   endtask

   vec_t    vecs[10];
   bundle_t e_beq, e_jal, e_ill, e_ebrk, e_addi;

   initial begin
      vecs[0] = '{32'h00500093, mk(32'h00500093, 32'h80000000, 32'h00000005, 4'd0, 2'd0, 10'b1100000000)};
      vecs[1] = '{32'h402081B3, mk(32'h402081B3, 32'h80000004, 32'h00000000, 4'd1, 2'd0, 10'b1000000000)};
      vecs[2] = '{32'h123452B7, mk(32'h123452B7, 32'h80000008, 32'h12345000, 4'd0, 2'd1, 10'b1000000000)};
      vecs[3] = '{32'h4033D313, mk(32'h4033D313, 32'h8000000C, 32'h00000403, 4'd7, 2'd0, 10'b1100000000)};
      vecs[4] = '{32'hFF812403, mk(32'hFF812403, 32'h80000010, 32'hFFFFFFF8, 4'd0, 2'd3, 10'b1100001000)};
      vecs[5] = '{32'h00912623, mk(32'h00912623, 32'h80000014, 32'h0000000C, 4'd0, 2'd0, 10'b0100000100)};
      vecs[6] = '{32'h00008067, mk(32'h00008067, 32'h80000018, 32'h00000000, 4'd0, 2'd2, 10'b1100100000)};
      vecs[7] = '{32'hFFFFF517, mk(32'hFFFFF517, 32'h8000001C, 32'hFFFFF000, 4'd0, 2'd0, 10'b1110000000)};
      vecs[8] = '{32'h00D635B3, mk(32'h00D635B3, 32'h80000020, 32'h00000000, 4'd4, 2'd0, 10'b1000000000)};
      vecs[9] = '{32'hFFF7C713, mk(32'hFFF7C713, 32'h80000024, 32'hFFFFFFFF, 4'd5, 2'd0, 10'b1100000000)};
      e_beq  = mk(32'hFE208EE3, 32'h80000100, 32'hFFFFFFFC, 4'd1, 2'd0, 10'b0000010000);
      e_jal  = mk(32'h008000EF, 32'h80000104, 32'h00000008, 4'd0, 2'd2, 10'b1111000000);
      e_ill  = mk(32'h000008B3, 32'h80000200, 32'h00000000, 4'd0, 2'd0, 10'b0000000001);
      e_ebrk = mk(32'h00100073, 32'h80000300, 32'h00000000, 4'd0, 2'd0, 10'b0000000010);
      e_addi = mk(32'h00500093, 32'h80000400, 32'h00000005, 4'd0, 2'd0, 10'b1100000000);

      rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
      cur_exp = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // back-to-back decode table with the EXU always ready
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].inst, vecs[i].exp);
         wait_acc($sformatf("accept_vec%0d", i));
      end
      idle(3);

      // BEQ held under back-pressure while a JAL waits upstream
      out_ready = 1'b0;
      drive(32'hFE208EE3, e_beq);
      wait_acc("accept_beq");
      drive(32'h008000EF, e_jal);
      repeat (3) begin @(posedge clk); #1; end
      out_ready = 1'b1;
      wait_acc("accept_jal");
      idle(3);

      // RV32E out-of-range rd: illegal bundle drains, then permanent halt
      drive(32'h000008B3, e_ill);
      wait_acc("accept_ill");
      drive(32'h00500093, e_addi);
      repeat (6) begin @(posedge clk); #1; end
      idle(1);
      do_reset(2);

      // EBREAK halts; a reset mid-HALT restores intake
      drive(32'h00100073, e_ebrk);
      wait_acc("accept_ebreak");
      drive(32'h00500093, e_addi);
      repeat (4) begin @(posedge clk); #1; end
      idle(1);
      do_reset(2);
      drive(32'h00500093, e_addi);
      wait_acc("accept_after_reset");
      idle(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/idu_pipe.md
Name: idu_pipe

Overview:
- Registered, parametrised instruction-decode stage for the NPC.
- Sits between the IFU fetch register and the EXU, with valid/ready handshakes on both sides.
- Decodes the full RV32I/RV32E base set into an ALU/memory/branch control bundle.
- Flags illegal instructions and EBREAK, and enters a sticky halt state after they drain.
- Keeps a count of accepted instructions.

Parameters:
- XLEN, 32: width of the PC and immediate datapath (32 or 64; immediates are sign-extended to XLEN).
- NR_REG, 32: architectural register count. 16 selects RV32E; any rs1/rs2/rd index >= 16 that is used by the instruction is illegal.
- CNT_W, 32: width of the decoded-instruction counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  IFU presents an instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  XLEN  PC of in_inst
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  EXU accepts the bundle
- out_pc  out  XLEN  registered PC
- out_imm  out  XLEN  sign-extended immediate (I/S/B/U/J)
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_funct3  out  3  inst[14:12], passed through for the LSU and branch unit
- out_reg_write  out  1  write-back enable
- out_alu_src  out  1  operand 2: 0 = rs2, 1 = imm
- out_alu_r1  out  1  operand 1: 0 = rs1, 1 = PC
- out_alu_ctrl  out  4  ALU op, encoded per idu_pkg
- out_wb_sel  out  2  write-back source: 0 = ALU, 1 = imm, 2 = PC+4, 3 = memory
- out_is_jal, out_is_jalr, out_is_branch, out_mem_read, out_mem_write  out  1 each  class flags
- out_ebreak, out_illegal  out  1 each  exception flags
- halt  out  1  sticky halt status
- dec_cnt  out  CNT_W  number of instructions accepted

Behaviour:
- Reset (rst_n low, asynchronous): every output register goes to 0; state goes to EMPTY; dec_cnt goes to 0. A reset in the middle of a transfer discards the held bundle.
- States:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
  - HALT: out_valid = 0, in_ready = 0, halt = 1.
- in_ready = (state == EMPTY) or (state == FULL and out_ready). It is combinational from out_ready, which gives a one-entry pipeline with a zero-bubble pass-through.
- Accept = in_valid and in_ready. On accept, all out_* register the decode of in_inst and in_pc.
  - Latency: exactly 1 cycle.
  - dec_cnt increments and wraps modulo 2^CNT_W.
- Transitions:
  - EMPTY to FULL on accept.
  - FULL to FULL on a simultaneous accept and out_ready.
  - FULL to EMPTY on out_ready with no accept.
  - FULL to HALT on out_ready when the held bundle has out_ebreak or out_illegal set.
- HALT is left only by reset.
  - If a halting bundle is held, in_ready is 0, so nothing follows it.
  - The halting bundle itself is delivered to the EXU normally.
- Stall: while FULL and out_ready = 0, all out_* hold their values.
- Decode, by opcode:
  - LUI: wb_sel = imm.
  - AUIPC: alu_r1 = 1, alu_src = 1.
  - OP-IMM: ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI; alu_src = 1.
  - OP: the 10 R-type ops. funct7 bit 30 selects SUB/SRA. Any other funct7 value is illegal.
  - JAL and JALR: wb_sel = PC+4; alu_src = 1. JAL has alu_r1 = 1.
  - BRANCH: alu_ctrl = SUB; reg_write = 0. funct3 values 2 and 3 are illegal.
  - LOAD: mem_read = 1; wb_sel = mem. funct3 values 3, 6 and 7 are illegal.
  - STORE: mem_write = 1; reg_write = 0. funct3 >= 3 is illegal.
  - SYSTEM word 0x00100073: ebreak = 1.
- Anything else is illegal.
- When an instruction is illegal or EBREAK: reg_write, mem_read, mem_write, is_jal, is_jalr and is_branch are all forced to 0.
- Writes to rd = x0: reg_write is still asserted; the register file ignores them.
- RV32E check: when NR_REG = 16, bit 4 of any register field used by the instruction's format makes it illegal.
- Immediates are sign-extended from bit 31 to XLEN; the U-type immediate is also sign-extended when XLEN = 64.

Decomposition:
- Shared package idu_pkg holds:
  - opcode constants;
  - alu_ctrl encoding (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND);
  - wb_sel encoding;
  - state encoding.
- One combinational sub-module, idu_decode, maps (inst) to the control bundle, illegal and ebreak.
- idu_pipe holds the handshake FSM, the output register and the counter.

Test Plan:
- Reset, then in_inst = 0x00500093 (ADDI x1,x0,5) with in_pc = 0x80000000 and out_ready = 1:
  - next cycle out_valid = 1, out_imm = 5, out_rd = 1, alu_src = 1, reg_write = 1, dec_cnt = 1.
- Back-to-back 0x402081B3 (SUB), then 0x123452B7 (LUI), with out_ready = 1:
  - the first bundle gives alu_ctrl = SUB, alu_src = 0;
  - the next cycle gives out_imm = 0x12345000, wb_sel = imm;
  - no bubble between them.
- 0xFE208EE3 (BEQ, offset -4) with out_ready held at 0 for 3 cycles:
  - out_imm = 0xFFFFFFFC, is_branch = 1, bundle stable throughout, in_ready = 0;
  - releasing out_ready gives one transfer.
- 0x008000EF (JAL x1,8):
  - out_imm = 8, wb_sel = PC+4, alu_r1 = 1, is_jal = 1.
- NR_REG = 16 with 0x000008B3 (rd = x17):
  - out_illegal = 1, reg_write = 0;
  - after the transfer, halt = 1 and in_ready = 0 forever.
- 0x00100073 (EBREAK):
  - out_ebreak = 1, then HALT;
  - rst_n asserted mid-HALT clears halt and dec_cnt, and the stage accepts again.
